// File: rtl/addertree_stage2.sv
// rtl/addertree_stage2.sv - column popcount reduction, group accumulator and 8-bit requantizer (optional ReLU clamp via ADDERTREE2_RELU_EN)
`timescale 1ns/1ps
module addertree_stage2 #(
  parameter int ACC_W = 24,
  parameter int SHIFT = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [118:0]            col_bits,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic signed [7:0]       q_out
);

  // Bit count of columns ao3..ao18, packed from the LSB of col_bits upwards.
  localparam int NCOL = 16;
  localparam int COL_W [NCOL] = '{6, 8, 9, 10, 10, 11, 12, 11, 10, 9, 7, 5, 5, 3, 2, 1};

`ifdef ADDERTREE2_RELU_EN
  localparam logic signed [ACC_W-1:0] Q_MIN = '0;
`else
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-128);
`endif
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(127);

  logic                    stall;
  logic [3:0]              pc_d [NCOL];
  logic [3:0]              pc_q [NCOL];
  logic                    v1, l1;
  logic [18:0]             psum_d, psum_q;
  logic                    v2, l2;
  logic signed [ACC_W-1:0] acc, psum_ext, sum_d, shifted;
  logic signed [7:0]       q_d;
  logic                    first;
  logic [6:0]              idx;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Popcount each column of the incoming beat.
  always_comb begin
    idx = '0;
    for (int k = 0; k < NCOL; k++) begin
      pc_d[k] = '0;
      for (int j = 0; j < 12; j++) begin
        if (j < COL_W[k]) begin
          pc_d[k] = pc_d[k] + {3'b000, col_bits[idx]};
          idx     = idx + 7'd1;
        end
      end
    end
  end

  // Weight each registered popcount by its column position; wraps at 19 bits.
  always_comb begin
    psum_d = '0;
    for (int k = 0; k < NCOL; k++) begin
      psum_d = psum_d + ({15'd0, pc_q[k]} << (k + 3));
    end
  end

  // Accumulate and requantize: first beat of a group loads, later beats add.
  always_comb begin
    psum_ext = ACC_W'(signed'(psum_q));
    sum_d    = first ? psum_ext : acc + psum_ext;
    shifted  = sum_d >>> SHIFT;
    if (shifted > Q_MAX)      q_d = 8'sd127;
    else if (shifted < Q_MIN) q_d = Q_MIN[7:0];
    else                      q_d = shifted[7:0];
  end

  // S1: popcount registers plus valid/last; everything holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      for (int k = 0; k < NCOL; k++) pc_q[k] <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      l1 <= in_valid && in_last;
      for (int k = 0; k < NCOL; k++) pc_q[k] <= pc_d[k];
    end
  end

  // S2: partial sum register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2     <= 1'b0;
      l2     <= 1'b0;
      psum_q <= '0;
    end else if (!stall) begin
      v2     <= v1;
      l2     <= v1 && l1;
      psum_q <= psum_d;
    end
  end

  // ACC: group accumulator and output holding register; a new result may overwrite one being taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      first     <= 1'b1;
      acc_out   <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (v2) begin
        if (l2) begin
          acc     <= '0;
          first   <= 1'b1;
          acc_out <= sum_d;
          q_out   <= q_d;
        end else begin
          acc   <= sum_d;
          first <= 1'b0;
        end
      end
      if (v2 && l2)      out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addertree_stage2.sv
// tb/tb_addertree_stage2.sv - directed and random checks of addertree_stage2 at SHIFT=7 and SHIFT=0
`timescale 1ns/1ps
module tb_addertree_stage2;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid, in_last, out_ready;
  logic [118:0]       col_bits;
  logic               in_ready, in_ready0;
  logic               out_valid, out_valid0;
  logic signed [23:0] acc_out, acc_out0;
  logic signed [7:0]  q_out, q_out0;

  int n_checks = 0;
  int n_fail   = 0;

  int got_acc [$];
  int got_q7  [$];
  int got_q0  [$];
  int exp_q   [$];

  always #5 clk = ~clk;

  addertree_stage2 #(.ACC_W(24), .SHIFT(7)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .col_bits(col_bits), .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .q_out(q_out)
  );

  addertree_stage2 #(.ACC_W(24), .SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .in_last(in_last),
    .col_bits(col_bits), .out_valid(out_valid0), .out_ready(out_ready), .acc_out(acc_out0), .q_out(q_out0)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each column's weight applied bit by bit, folded to a signed 19-bit value.
  function automatic int psum_model(input logic [118:0] b);
    int wid [16] = '{6, 8, 9, 10, 10, 11, 12, 11, 10, 9, 7, 5, 5, 3, 2, 1};
    int pos = 0;
    int s = 0;
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < wid[k]; j++) begin
        if (b[pos]) s += (1 << (k + 3));
        pos++;
      end
    s = s & 32'h7FFFF;
    if (s >= 32'h40000) s -= 32'h80000;
    return s;
  endfunction

  function automatic int q_model(input int v, input int sh);
    int s = v >>> sh;
`ifdef ADDERTREE2_RELU_EN
    if (s < 0) s = 0;
`else
    if (s < -128) s = -128;
`endif
    if (s > 127) s = 127;
    return s;
  endfunction

  // Record every result at the negedge before the edge that hands it over.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      got_acc.push_back(int'(acc_out));
      got_q7.push_back(int'(q_out));
      got_q0.push_back(int'(q_out0));
    end
  end

  task automatic send_beat(input logic [118:0] b, input logic last);
    int n = 0;
    col_bits = b;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int exp_acc);
    int n = 0;
    while (got_acc.size() == 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (got_acc.size() == 0) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_acc"}, got_acc.pop_front(), exp_acc);
      check({tag, "_q7"}, got_q7.pop_front(), q_model(exp_acc, 7));
      check({tag, "_q0"}, got_q0.pop_front(), q_model(exp_acc, 0));
    end
  endtask

  localparam logic [118:0] B_AO3  = 119'd1;
  localparam logic [118:0] B_AO18 = 119'd1 << 118;
  localparam logic [118:0] B_AO9  = 119'hFFF << 54;

  initial begin
    logic [127:0] r;
    int exp_acc, nb, n;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; col_bits = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_acc_out", int'(acc_out), 0);
    check("rst_q_out", int'(q_out), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);

    // Single beat of value 8, with latency check.
    send_beat(B_AO3, 1'b1);
    @(posedge clk);
    #1;
    check("lat_early", int'(out_valid), 0);
    @(posedge clk);
    #1;
    check("lat_valid", int'(out_valid), 1);
    expect_result("ao3", 8);

    // Single beat with the sign column only.
    send_beat(B_AO18, 1'b1);
    expect_result("ao18", -262144);

    // Four back-to-back ao9 beats, then one alone.
    for (int i = 0; i < 4; i++) send_beat(B_AO9, i == 3);
    expect_result("ao9x4", 24576);
    send_beat(B_AO9, 1'b1);
    expect_result("ao9x1", 6144);
    check("psum_model_ao9", psum_model(B_AO9), 6144);

    // Back-pressure: result held while out_ready is low.
    out_ready = 1'b0;
    send_beat(B_AO3, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_valid", int'(out_valid), 1);
    col_bits = B_AO9; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_acc", int'(acc_out), 8);
      check("stall_q0", int'(q_out0), 8);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_beat(B_AO9, 1'b0);
    send_beat(B_AO9, 1'b1);
    expect_result("stall_first", 8);
    expect_result("stall_second", 12288);

    // Random groups with bubbles.
    for (int g = 0; g < 8; g++) begin
      nb = $urandom_range(1, 6);
      exp_acc = 0;
      for (int b = 0; b < nb; b++) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        exp_acc += psum_model(r[118:0]);
        send_beat(r[118:0], b == nb - 1);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      exp_q.push_back(exp_acc);
    end
    while (exp_q.size() != 0) expect_result("rand", exp_q.pop_front());

    // Reset mid-group discards the partial accumulation.
    send_beat(B_AO9, 1'b0);
    send_beat(B_AO18, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_acc_out", int'(acc_out), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_output", got_acc.size(), 0);
    send_beat(B_AO3, 1'b1);
    expect_result("midrst_new", 8);

    repeat (5) @(posedge clk);
    #1;
    check("no_extra_results", got_acc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addertree_stage2.md
Name: addertree_stage2

Overview:
- Downstream consumer of `addertree_stage1`.
- Takes its column-bit vectors (`ao18`..`ao3`), which already include the 3x3 products and the bias, and reduces them to one signed 19-bit partial sum.
- Accumulates partial sums over a group of beats, one beat per 9-input slice, so kernels deeper than one channel are supported.
- Emits the group total at full accumulator width plus a saturated 8-bit requantized value for the next layer. Pipelined with a valid/ready handshake.

Parameters:
- ACC_W, 24, accumulator/output width in bits; must be ≥ 19.
- SHIFT, 7, arithmetic right shift applied before 8-bit saturation; legal range 0..ACC_W-1.

Ports:
- clk  in  1  clock, all state on the rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept a beat this cycle
- in_last  in  1  marks the final beat of the accumulation group
- col_bits  in  119  concatenation {ao18[0:0], ao17[1:0], ao16[2:0], ao15[4:0], ao14[4:0], ao13[6:0], ao12[8:0], ao11[9:0], ao10[10:0], ao9[11:0], ao8[10:0], ao7[9:0], ao6[9:0], ao5[8:0], ao4[7:0], ao3[5:0]}, ao18 at the MSB
- out_valid  out  1  group result available
- out_ready  in  1  consumer takes the result
- acc_out  out  ACC_W  signed group total
- q_out  out  8  signed saturated requantized result

Behaviour:
- Beat accepted when `in_valid && in_ready`.
- Global stall `stall = out_valid && !out_ready`. `in_ready = !stall`. While stalled, all pipeline registers hold.
- S1 (edge after accept):
  - Register per-column popcounts; column k has weight 2^k, k = 3..18.
  - Register valid and last.
- S2 (next edge):
  - Register `psum = sum(popcount_k << k)` modulo 2^19, interpreted as signed 19-bit.
  - Bits [2:0] are always 0.
- ACC (next edge):
  - First beat of a group (after reset or after a last beat): `acc = sext(psum)`.
  - Otherwise: `acc = acc + sext(psum)`.
  - Wraps modulo 2^ACC_W; no overflow flag.
- Last beat at ACC:
  - `acc_out` gets the final sum.
  - `q_out = sat8(final >>> SHIFT)`, clamped to [-128, 127].
  - `out_valid` is set to 1 and the group restarts.
- Latency: last beat accepted at edge t gives `out_valid` high after edge t+3. Throughput is 1 beat/cycle when not stalled.
- `out_valid` stays high, with `acc_out`/`q_out` stable, until `out_ready` is seen high at an edge.
  - If a new result arrives on the same edge, it replaces the old one and `out_valid` remains 1.
- Single-beat group (in_last on the first beat) is legal: result = sext(psum).
- Bubbles (in_valid = 0) between beats of a group do not disturb the accumulator.
- Reset values, asynchronous and immediate, including mid-group:
  - All pipeline valids = 0.
  - acc = 0.
  - `acc_out` = 0, `q_out` = 0, `out_valid` = 0.
  - Group state = "first beat".
  - `in_ready` = 1 once reset deasserts.
  - A partially accumulated group is discarded.
- All-zero `col_bits` is a valid beat (psum = 0).

Optional Feature:
- Macro `ADDERTREE2_RELU_EN`.
- Defined: `q_out = min(max(final >>> SHIFT, 0), 127)`. Negative totals give 0. `acc_out` is unchanged (raw).
- Undefined: `q_out` is the signed clamp to [-128, 127] as above.

Test Plan:
- Reset then a single beat, only ao3 bit0 set, in_last = 1, SHIFT = 0 → after 3 edges out_valid = 1, acc_out = 8, q_out = 8.
- Single beat, only ao18 set, in_last = 1 → acc_out = -262144 (sign-extended); q_out = -128 (ReLU build: 0).
- Group of 4 back-to-back beats, each with all ao9 bits set (12 × 512 = 6144), SHIFT = 7 → acc_out = 24576, q_out = 127 (saturated). Each beat alone gives 48.
- Result pending, out_ready held 0 for 5 cycles while in_valid = 1 → in_ready = 0, acc_out/q_out stable. out_ready = 1 releases; no beat lost or duplicated.
- Random `col_bits` driven through the upstream multiplier/`addertree_stage1` with groups of 1..16 beats and in_valid gaps → acc_out equals Σ(9·a·b + bias) within ±32 per beat.
- Reset asserted mid-group after 2 of 3 beats, then a new single beat of value 8 → acc_out = 8, and no output ever appears for the aborted group.
